kbd_event_scheduler: RTL and testbench



---
 rtl/kbd_pkg.sv | 33 +++
 rtl/kbd_inj_fifo.sv | 50 +++++
 rtl/kbd_event_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_kbd_event_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event scheduler.
package kbd_pkg;

   typedef enum logic [2:0] {
      ST_ARM,
      ST_IDLE,
      ST_SH_DN,
      ST_KEY_DN,
      ST_HOLD,
      ST_KEY_UP,
      ST_SH_UP,
      ST_GAP
   } kbd_state_t;

   localparam logic [7:0] SC_LSHIFT = 8'h12;

   localparam int EV_TOG  = 10;
   localparam int EV_REL  = 9;
   localparam int EV_EXT  = 8;

   // FIFO entry layout: {shift, code}
   localparam int ENTRY_W = 9;

   // Low ten bits of an injected event word; injected keys are never extended.
   function automatic logic [9:0] inj_word(input logic rel, input logic [7:0] code);
      logic [9:0] w;
      w         = {2'b00, code};
      w[EV_REL] = rel;
      w[EV_EXT] = 1'b0;
      return w;
   endfunction

endpackage

// File: rtl/kbd_inj_fifo.sv
// Injection queue: DEPTH x {shift,code}, show-ahead read, flush clears it in one edge.
module kbd_inj_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               wr_en,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               rd_en,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage array; a write that coincides with a flush is discarded.
   always_ff @(posedge clock) begin
      if (wr_en && !full && !flush) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Read/write pointers with an extra wrap bit to tell full from empty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/kbd_event_scheduler.sv
// Merges live PS/2 events with queued injected keys into one toggle-encoded event word.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ARM    | first cycle after reset, seeds the host toggle reference
// ST_IDLE   | waiting for a queued entry
// ST_SH_DN  | emit left-shift press
// ST_KEY_DN | emit key press, load hold counter
// ST_HOLD   | key held down, counting
// ST_KEY_UP | emit key release
// ST_SH_UP  | emit left-shift release
// ST_GAP    | idle spacing after the final release, counting
module kbd_event_scheduler
   import kbd_pkg::*;
#(
   parameter logic [15:0] HOLD  = 16'd24000,
   parameter logic [15:0] GAP   = 16'd24000,
   parameter int          DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [10:0] ps2_in,
   input  logic        inj_valid,
   output logic        inj_ready,
   input  logic [7:0]  inj_code,
   input  logic        inj_shift,
   input  logic        abort,
   output logic [10:0] ps2_out,
   output logic        busy
);

   logic [10:0]        ps2_q;
   logic               prev_tog;
   logic               ev_q;
   logic [9:0]         ev_data;

   kbd_state_t         state;
   kbd_state_t         state_nx;
   logic [15:0]        cnt;
   logic [15:0]        cnt_nx;
   logic [7:0]         cur_code;
   logic               cur_shift;
   logic               abt_q;
   logic               abt_eff;

   logic               emit;
   logic [9:0]         emit_data;
   logic               pop;
   logic               fifo_wr;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic               fifo_full;
   logic               fifo_empty;

   assign inj_ready = !fifo_full && (state != ST_ARM);
   assign fifo_wr   = inj_valid && inj_ready && !abort;
   assign busy      = !fifo_empty || ((state != ST_IDLE) && (state != ST_ARM));
   assign abt_eff   = abort || abt_q;

   kbd_inj_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush   (abort),
      .wr_en   (fifo_wr),
      .wr_data ({inj_shift, inj_code}),
      .rd_en   (pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Host toggle detector; ARM seeds the reference so the reset value of ps2_in is never an event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ps2_q    <= '0;
         prev_tog <= 1'b0;
         ev_q     <= 1'b0;
         ev_data  <= '0;
      end else begin
         ps2_q    <= ps2_in;
         prev_tog <= (state == ST_ARM) ? ps2_in[EV_TOG] : ps2_q[EV_TOG];
         ev_q     <= (state != ST_ARM) && (ps2_q[EV_TOG] != prev_tog);
         ev_data  <= ps2_q[9:0];
      end
   end

   // FSM state, counter, current entry and the sticky abort flag that skips GAP.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_ARM;
         cnt       <= '0;
         cur_code  <= '0;
         cur_shift <= 1'b0;
         abt_q     <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (pop) begin
            cur_shift <= fifo_rdata[ENTRY_W-1];
            cur_code  <= fifo_rdata[7:0];
         end
         if (abort) abt_q <= 1'b1;
         else if (state == ST_IDLE) abt_q <= 1'b0;
      end
   end

   // Next-state and emit decode; emit states hold whenever a host event owns the output.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      emit      = 1'b0;
      emit_data = '0;
      pop       = 1'b0;
      case (state)
         ST_ARM: state_nx = ST_IDLE;
         ST_IDLE: begin
            if (!abort && !fifo_empty) begin
               pop      = 1'b1;
               state_nx = fifo_rdata[ENTRY_W-1] ? ST_SH_DN : ST_KEY_DN;
            end
         end
         ST_SH_DN: begin
            if (abort) begin
               state_nx = ST_IDLE;
            end else if (!ev_q) begin
               emit      = 1'b1;
               emit_data = inj_word(1'b0, SC_LSHIFT);
               state_nx  = ST_KEY_DN;
            end
         end
         ST_KEY_DN: begin
            if (abort) begin
               state_nx = ST_KEY_UP;
            end else if (!ev_q) begin
               emit      = 1'b1;
               emit_data = inj_word(1'b0, cur_code);
               cnt_nx    = HOLD;
               state_nx  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (abort || cnt <= 16'd1) state_nx = ST_KEY_UP;
            else cnt_nx = cnt - 16'd1;
         end
         ST_KEY_UP: begin
            if (!ev_q) begin
               emit      = 1'b1;
               emit_data = inj_word(1'b1, cur_code);
               if (cur_shift) begin
                  state_nx = ST_SH_UP;
               end else if (abt_eff) begin
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_GAP;
                  cnt_nx   = GAP;
               end
            end
         end
         ST_SH_UP: begin
            if (!ev_q) begin
               emit      = 1'b1;
               emit_data = inj_word(1'b1, SC_LSHIFT);
               if (abt_eff) begin
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_GAP;
                  cnt_nx   = GAP;
               end
            end
         end
         ST_GAP: begin
            if (abort || cnt <= 16'd1) state_nx = ST_IDLE;
            else cnt_nx = cnt - 16'd1;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Output word: each emitted event flips the toggle bit; host events take priority.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ps2_out <= '0;
      end else if (ev_q) begin
         ps2_out <= {~ps2_out[EV_TOG], ev_data};
      end else if (emit) begin
         ps2_out <= {~ps2_out[EV_TOG], emit_data};
      end
   end

endmodule

// File: tb/tb_kbd_event_scheduler.sv
// Bench for kbd_event_scheduler: directed scenarios plus randomized traffic against an action-list model.
module tb_kbd_event_scheduler;

   localparam logic [15:0] HOLD  = 16'd4;
   localparam logic [15:0] GAP   = 16'd2;
   localparam int          DEPTH = 16;

   localparam int T_SHDN = 0, T_KDN = 1, T_HOLD = 2, T_KUP = 3, T_SHUP = 4, T_GAP = 5;

   logic        clock = 1'b0;
   logic        reset;
   logic [10:0] ps2_in;
   logic        inj_valid;
   logic        inj_ready;
   logic [7:0]  inj_code;
   logic        inj_shift;
   logic        abort;
   logic [10:0] ps2_out;
   logic        busy;

   always #5 clock = ~clock;

   kbd_event_scheduler #(
      .HOLD  (HOLD),
      .GAP   (GAP),
      .DEPTH (DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ps2_in    (ps2_in),
      .inj_valid (inj_valid),
      .inj_ready (inj_ready),
      .inj_code  (inj_code),
      .inj_shift (inj_shift),
      .abort     (abort),
      .ps2_out   (ps2_out),
      .busy      (busy)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         tag;
      logic [9:0] d;
      int         n;
   } act_t;

   act_t        acts[$];
   logic [8:0]  fq[$];
   logic [10:0] exp_out;
   logic        armed;
   logic [10:0] last_in;
   logic        hp0_v, hp1_v;
   logic [9:0]  hp0_d, hp1_d;
   logic [7:0]  m_code;
   logic        m_shift;

   function automatic act_t mk(input int tag, input logic [9:0] d, input int n);
      act_t a;
      a.tag = tag; a.d = d; a.n = n;
      return a;
   endfunction

   task automatic model_reset();
      acts.delete(); fq.delete();
      exp_out = '0; armed = 1'b0; last_in = '0;
      hp0_v = 1'b0; hp1_v = 1'b0; hp0_d = '0; hp1_d = '0;
      m_code = '0; m_shift = 1'b0;
   endtask

   task automatic run_head(input logic host_now);
      if (acts[0].tag == T_HOLD || acts[0].tag == T_GAP) begin
         acts[0].n = acts[0].n - 1;
         if (acts[0].n <= 0) void'(acts.pop_front());
      end else if (!host_now) begin
         exp_out = {~exp_out[10], acts[0].d};
         void'(acts.pop_front());
      end
   endtask

   task automatic model_step();
      logic       host_now;
      logic       can_wr;
      logic [8:0] e;
      if (!armed) begin
         armed   = 1'b1;
         last_in = ps2_in;
         return;
      end
      host_now = hp1_v;
      if (host_now) exp_out = {~exp_out[10], hp1_d};
      hp1_v = hp0_v; hp1_d = hp0_d;
      hp0_v = (ps2_in[10] != last_in[10]); hp0_d = ps2_in[9:0];
      last_in = ps2_in;
      can_wr = inj_valid && (fq.size() < DEPTH) && !abort;
      if (abort) begin
         fq.delete();
         if (acts.size() > 0) begin
            case (acts[0].tag)
               T_SHDN, T_GAP: acts.delete();
               T_KDN, T_HOLD: begin
                  acts.delete();
                  acts.push_back(mk(T_KUP, {2'b10, m_code}, 0));
                  if (m_shift) acts.push_back(mk(T_SHUP, 10'h212, 0));
               end
               default: begin
                  if (acts[acts.size()-1].tag == T_GAP) void'(acts.pop_back());
                  run_head(host_now);
               end
            endcase
         end
      end else if (acts.size() == 0) begin
         if (fq.size() > 0) begin
            e       = fq.pop_front();
            m_shift = e[8];
            m_code  = e[7:0];
            if (m_shift) acts.push_back(mk(T_SHDN, 10'h012, 0));
            acts.push_back(mk(T_KDN, {2'b00, m_code}, 0));
            acts.push_back(mk(T_HOLD, 10'h000, int'(HOLD)));
            acts.push_back(mk(T_KUP, {2'b10, m_code}, 0));
            if (m_shift) acts.push_back(mk(T_SHUP, 10'h212, 0));
            acts.push_back(mk(T_GAP, 10'h000, int'(GAP)));
         end
      end else begin
         run_head(host_now);
      end
      if (can_wr) fq.push_back({inj_shift, inj_code});
   endtask

   // ---------------- clocking helpers ----------------
   int          cyc = 0;
   int          fall_cyc;
   logic [10:0] obs_prev = '0;
   logic [9:0]  ev_log[$];
   int          ev_cyc[$];

   task automatic tick();
      @(posedge clock);
      cyc++;
      if (!reset) model_step();
      @(negedge clock);
      check("ps2_out", 32'(ps2_out), 32'(exp_out));
      check("busy", 32'(busy), 32'((fq.size() > 0) || (acts.size() > 0)));
      check("inj_ready", 32'(inj_ready), 32'(armed && (fq.size() < DEPTH)));
      if (ps2_out !== obs_prev) begin
         ev_log.push_back(ps2_out[9:0]);
         ev_cyc.push_back(cyc);
      end
      obs_prev = ps2_out;
   endtask

   task automatic wait_idle(input int max);
      int k;
      k = 0;
      while (busy && k < max) begin
         tick();
         k++;
      end
      fall_cyc = cyc;
      check("drain_busy", 32'(busy), 32'd0);
   endtask

   function automatic logic [9:0] evat(input int i);
      return (i < ev_log.size()) ? ev_log[i] : 10'h3FF;
   endfunction

   function automatic int cycat(input int i);
      return (i < ev_cyc.size()) ? ev_cyc[i] : -1000;
   endfunction

   task automatic clear_log();
      ev_log.delete();
      ev_cyc.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n0, w, presses, k;
      logic [7:0] last_press;
      logic [9:0] p3_exp [4];
      p3_exp = '{10'h012, 10'h01C, 10'h21C, 10'h212};

      // 1: reset with toggle bit high, no spurious event
      reset = 1'b1; ps2_in = 11'h400; inj_valid = 1'b0; inj_code = '0; inj_shift = 1'b0; abort = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      check("rst_ps2_out", 32'(ps2_out), 32'h000);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(inj_ready), 32'd0);
      reset = 1'b0;
      clear_log();
      tick();
      check("arm_ready", 32'(inj_ready), 32'd1);
      repeat (10) tick();
      check("p1_no_event", 32'(ev_log.size()), 32'd0);

      // 2: host pass-through, two-edge latency, data-only change ignored
      clear_log();
      ps2_in = 11'h01C; tick(); n0 = cyc; repeat (3) tick();
      ps2_in = 11'h41C; tick(); repeat (3) tick();
      ps2_in = 11'h21C; tick(); repeat (3) tick();
      ps2_in = 11'h0AA; repeat (4) tick();
      check("p2_nev", 32'(ev_log.size()), 32'd3);
      check("p2_ev0", 32'(evat(0)), 32'h01C);
      check("p2_ev2", 32'(evat(2)), 32'h21C);
      check("p2_lat0", 32'(cycat(0) - n0), 32'd2);
      check("p2_lat2", 32'(cycat(2) - n0), 32'd10);

      // 3: shifted injection sequence and timing
      clear_log();
      inj_valid = 1'b1; inj_code = 8'h1C; inj_shift = 1'b1;
      tick(); w = cyc;
      inj_valid = 1'b0;
      wait_idle(100);
      check("p3_nev", 32'(ev_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("p3_ev%0d", i), 32'(evat(i)), 32'(p3_exp[i]));
      check("p3_first", 32'(cycat(0) - w), 32'd2);
      check("p3_press", 32'(cycat(1) - cycat(0)), 32'd1);
      check("p3_hold", 32'(cycat(2) - cycat(1)), 32'(int'(HOLD) + 1));
      check("p3_shup", 32'(cycat(3) - cycat(2)), 32'd1);
      check("p3_gap", 32'(fall_cyc - cycat(3)), 32'(GAP));

      // 4: host event collides with the injected press
      clear_log();
      ps2_in = 11'h423; inj_valid = 1'b1; inj_code = 8'h1C; inj_shift = 1'b0;
      tick(); w = cyc;
      inj_valid = 1'b0;
      repeat (3) tick();
      check("p4_host_first", 32'(evat(0)), 32'h023);
      check("p4_host_cyc", 32'(cycat(0) - w), 32'd2);
      check("p4_inj_next", 32'(evat(1)), 32'h01C);
      check("p4_inj_cyc", 32'(cycat(1) - w), 32'd3);
      wait_idle(100);

      // 5: fill the FIFO while a host storm stalls the FSM
      clear_log();
      for (int i = 0; i < 20; i++) begin
         ps2_in = {~ps2_in[10], 10'h033};
         inj_valid = 1'b1; inj_code = 8'h40 + 8'(i); inj_shift = 1'b0;
         if (i == 17) check("p5_full", 32'(inj_ready), 32'd0);
         tick();
      end
      inj_valid = 1'b0;
      wait_idle(1000);
      presses = 0; last_press = '0;
      for (int i = 0; i < ev_log.size(); i++) begin
         if (ev_log[i][9] == 1'b0 && ev_log[i][7:0] >= 8'h40 && ev_log[i][7:0] <= 8'h53) begin
            presses++;
            last_press = ev_log[i][7:0];
         end
      end
      check("p5_presses", 32'(presses), 32'd17);
      check("p5_last_code", 32'(last_press), 32'h50);

      // 6: abort during HOLD of a shifted key with entries queued
      clear_log();
      inj_valid = 1'b1; inj_code = 8'h24; inj_shift = 1'b1; tick();
      inj_code = 8'h31; inj_shift = 1'b0; tick();
      inj_code = 8'h32; tick();
      inj_code = 8'h33; tick();
      inj_valid = 1'b0;
      k = 0;
      while (!(ev_log.size() > 0 && ev_log[ev_log.size()-1] == 10'h024) && k < 60) begin
         tick();
         k++;
      end
      check("p6_press_seen", 32'(evat(ev_log.size() - 1)), 32'h024);
      tick();
      clear_log();
      abort = 1'b1; tick(); abort = 1'b0;
      wait_idle(3);
      repeat (30) tick();
      check("p6_nev", 32'(ev_log.size()), 32'd2);
      check("p6_ev0", 32'(evat(0)), 32'h224);
      check("p6_ev1", 32'(evat(1)), 32'h212);

      // 7: randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         k = int'($urandom_range(7));
         if ((i % 400) < 5 || k == 0) ps2_in = {~ps2_in[10], 10'($urandom)};
         else if (k == 1) ps2_in = {ps2_in[10], 10'($urandom)};
         inj_valid = ($urandom_range(3) == 0);
         inj_code  = 8'($urandom);
         inj_shift = 1'($urandom);
         abort     = ($urandom_range(99) == 0);
         tick();
      end
      inj_valid = 1'b0; abort = 1'b0;
      wait_idle(2000);

      // 8: reset in the middle of an injected key
      inj_valid = 1'b1; inj_code = 8'h2B; inj_shift = 1'b0; tick();
      inj_valid = 1'b0; repeat (3) tick();
      reset = 1'b1; model_reset();
      #1;
      check("mid_rst_out", 32'(ps2_out), 32'h000);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
